// File: rtl/clk_switch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clk_switch_ctrl
//  Description : Sequencer that applies a requested clk1 source select and
//                clk1/clk3 enables to a clock reset generator. A source change
//                is made glitch-safe by gating clk1 off, letting it settle,
//                switching the select, settling again and then applying the
//                requested enables.
//
//                Optional PLL lock monitor, enabled by defining the macro
//                CLK_SWITCH_CTRL_LOCK_MON_EN. It synchronizes pll_locked,
//                aborts any sequence on lock loss, forces the enables low,
//                raises a sticky lock_err and holds off new commands until
//                lock returns.
//
//  Parameters  : SETTLE_CYC  settle cycles per sequence step (1..255)
//  Ports       : clk_ctrl       in   block clock (rising edge)
//                rst_clk_ctrl   in   asynchronous active-high reset
//                cmd_valid      in   command presented
//                cmd_ready      out  command accepted this cycle if valid
//                cmd_sel        in   requested clk1 source select
//                cmd_en1        in   requested clk1 enable
//                cmd_en3        in   requested clk3 enable
//                pll_locked     in   PLL lock, asynchronous to clk_ctrl
//                clk1_sel       out  CRG clk1 source select
//                clk1_en        out  CRG clk1 enable
//                clk3_en        out  CRG clk3 enable
//                busy           out  sequence in progress
//                done           out  one-cycle pulse when settings applied
//                lock_err       out  sticky lock-loss flag
//
//  Revision    : 1.0  initial release
// ============================================================================
module clk_switch_ctrl #(
    parameter int unsigned SETTLE_CYC = 8
) (
    input  logic clk_ctrl,
    input  logic rst_clk_ctrl,
    input  logic cmd_valid,
    output logic cmd_ready,
    input  logic cmd_sel,
    input  logic cmd_en1,
    input  logic cmd_en3,
    input  logic pll_locked,
    output logic clk1_sel,
    output logic clk1_en,
    output logic clk3_en,
    output logic busy,
    output logic done,
    output logic lock_err
);

    // A value of 0 is not legal: the wait states would count through 255.
    localparam logic [7:0] c_settle = 8'(SETTLE_CYC);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GATE_OFF = 3'd1,
        S_WAIT_OFF = 3'd2,
        S_SWITCH   = 3'd3,
        S_WAIT_SW  = 3'd4,
        S_APPLY    = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_state_nx;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nx;
    logic [7:0] w_cnt_dec;

    logic r_cmd_sel;
    logic r_cmd_en1;
    logic r_cmd_en3;

    logic r_clk1_sel;
    logic r_clk1_en;
    logic r_clk3_en;
    logic r_busy;
    logic r_done;
    logic r_cmd_ready;

    logic w_clk1_sel_nx;
    logic w_clk1_en_nx;
    logic w_clk3_en_nx;
    logic w_busy_nx;
    logic w_done_nx;
    logic w_cmd_ready_nx;

    logic w_sel_tgt;
    logic w_en1_tgt;
    logic w_en3_tgt;
    logic w_accept;
    logic w_lock_ok;

    // ------------------------------------------------------------------------
    // Lock monitor
    // ------------------------------------------------------------------------
`ifdef CLK_SWITCH_CTRL_LOCK_MON_EN
    logic r_lock_s1;
    logic r_lock_s2;
    logic r_lock_s3;
    logic r_lock_err;
    logic w_lock_fall;
    logic w_lock_err_nx;

    // r_lock_s3 is only a delayed copy of the synchronized lock, used to
    // detect its falling edge so lock_err is not raised while lock is still
    // coming up after reset.
    always_ff @(posedge clk_ctrl or posedge rst_clk_ctrl) begin
        if (rst_clk_ctrl) begin
            r_lock_s1  <= 1'b0;
            r_lock_s2  <= 1'b0;
            r_lock_s3  <= 1'b0;
            r_lock_err <= 1'b0;
        end else begin
            r_lock_s1  <= pll_locked;
            r_lock_s2  <= r_lock_s1;
            r_lock_s3  <= r_lock_s2;
            r_lock_err <= w_lock_err_nx;
        end
    end

    assign w_lock_ok     = r_lock_s2;
    assign w_lock_fall   = r_lock_s3 & ~r_lock_s2;
    // A lock loss in the same cycle as an accept wins: the flag must not be lost.
    assign w_lock_err_nx = w_lock_fall ? 1'b1 : (w_accept ? 1'b0 : r_lock_err);
    assign lock_err      = r_lock_err;
`else
    logic w_unused_lock;

    assign w_unused_lock = pll_locked;
    assign w_lock_ok     = 1'b1;
    assign lock_err      = 1'b0;
`endif

    assign w_accept  = cmd_valid & r_cmd_ready & w_lock_ok;
    assign w_cnt_dec = r_cnt - 8'd1;

    // ------------------------------------------------------------------------
    // Next-state and next-output logic. Every output is a register loaded
    // from the value it must have in the upcoming state, so an output is
    // already correct in the first cycle of that state.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;

        // On the accept cycle the latches are not loaded yet, so the target
        // settings come straight from the command inputs.
        w_sel_tgt = w_accept ? cmd_sel : r_cmd_sel;
        w_en1_tgt = w_accept ? cmd_en1 : r_cmd_en1;
        w_en3_tgt = w_accept ? cmd_en3 : r_cmd_en3;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (cmd_sel == r_clk1_sel) begin
                        w_state_nx = S_APPLY;
                    end else if (r_clk1_en) begin
                        w_state_nx = S_GATE_OFF;
                    end else begin
                        w_state_nx = S_SWITCH;
                    end
                end
            end
            S_GATE_OFF: begin
                w_cnt_nx   = c_settle;
                w_state_nx = S_WAIT_OFF;
            end
            S_WAIT_OFF: begin
                // The count reaches 0 on the edge that leaves, giving
                // SETTLE_CYC cycles in this state.
                w_cnt_nx = w_cnt_dec;
                if (w_cnt_dec == 8'd0) begin
                    w_state_nx = S_SWITCH;
                end
            end
            S_SWITCH: begin
                w_cnt_nx   = c_settle;
                w_state_nx = S_WAIT_SW;
            end
            S_WAIT_SW: begin
                w_cnt_nx = w_cnt_dec;
                if (w_cnt_dec == 8'd0) begin
                    w_state_nx = S_APPLY;
                end
            end
            S_APPLY: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = 8'd0;
            end
        endcase

        // Lock loss abandons whatever was in progress.
        if (!w_lock_ok) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = 8'd0;
        end

        // The select only moves when entering SWITCH, where clk1_en is
        // already low, so it can never change under a running clock.
        w_clk1_sel_nx = (w_state_nx == S_SWITCH) ? w_sel_tgt : r_clk1_sel;

        case (w_state_nx)
            S_APPLY: w_clk1_en_nx = w_en1_tgt;
            S_IDLE:  w_clk1_en_nx = r_clk1_en & w_lock_ok;
            default: w_clk1_en_nx = 1'b0;
        endcase

        if (!w_lock_ok) begin
            w_clk3_en_nx = 1'b0;
        end else if (w_state_nx == S_APPLY) begin
            w_clk3_en_nx = w_en3_tgt;
        end else begin
            w_clk3_en_nx = r_clk3_en;
        end

        w_done_nx      = (w_state_nx == S_APPLY);
        w_busy_nx      = (w_state_nx != S_IDLE);
        w_cmd_ready_nx = (w_state_nx == S_IDLE) & w_lock_ok;
    end

    // ------------------------------------------------------------------------
    // State, counter, command latch and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_ctrl or posedge rst_clk_ctrl) begin
        if (rst_clk_ctrl) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_cmd_sel   <= 1'b0;
            r_cmd_en1   <= 1'b0;
            r_cmd_en3   <= 1'b0;
            r_clk1_sel  <= 1'b0;
            r_clk1_en   <= 1'b0;
            r_clk3_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cmd_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_clk1_sel  <= w_clk1_sel_nx;
            r_clk1_en   <= w_clk1_en_nx;
            r_clk3_en   <= w_clk3_en_nx;
            r_busy      <= w_busy_nx;
            r_done      <= w_done_nx;
            r_cmd_ready <= w_cmd_ready_nx;
            if (w_accept) begin
                r_cmd_sel <= cmd_sel;
                r_cmd_en1 <= cmd_en1;
                r_cmd_en3 <= cmd_en3;
            end
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign clk1_sel  = r_clk1_sel;
    assign clk1_en   = r_clk1_en;
    assign clk3_en   = r_clk3_en;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire
